// File: rtl/countdown_pkg.sv
// Shared types and default constants for the countdown timer block.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } cd_state_t;

    // 50000 clk cycles per tick gives 1 ms at 50 MHz
    localparam int SCALE_FACTOR_DEFAULT = 50000;
    localparam int COUNT_W_DEFAULT      = 11;

endpackage

// File: rtl/countdown_controller_if.sv
// Button/switch inputs and display-facing outputs of the countdown controller.
// Handshake: there is no valid/ready pair here; btn_start, btn_clear and
// load_value are level inputs sampled on every rising clk edge, and every
// output is registered and valid for the whole cycle after the edge.
interface countdown_controller_if
    import countdown_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) ();

    logic               btn_start;
    logic               btn_clear;
    logic [COUNT_W-1:0] load_value;
    logic [COUNT_W-1:0] count;
    logic               running;
    logic               paused;
    logic               expired;
    logic               done_pulse;
    cd_state_t          state_dbg;

    // Drives the buttons and switches (top_level or a bench)
    modport master (
        output btn_start, btn_clear, load_value,
        input  count, running, paused, expired, done_pulse, state_dbg
    );

    // The controller itself
    modport slave (
        input  btn_start, btn_clear, load_value,
        output count, running, paused, expired, done_pulse, state_dbg
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk by SCALE_FACTOR while enabled; tick marks the wrap cycle.
module tick_prescaler #(
    parameter int SCALE_FACTOR = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = (SCALE_FACTOR > 1) ? $clog2(SCALE_FACTOR) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCALE_FACTOR - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap only while enabled
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/countdown_controller.sv
// Countdown sequencing FSM: load, prescaled decrement, pause/resume, clear.
module countdown_controller
    import countdown_pkg::*;
#(
    parameter int SCALE_FACTOR = SCALE_FACTOR_DEFAULT,
    parameter int COUNT_W      = COUNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    countdown_controller_if.slave  cd
);

    cd_state_t          state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               done_pulse_q, done_pulse_d;
    logic               start_prev_q;
    logic               start_evt;
    logic               presc_clear;
    logic               presc_en;
    logic               tick;

    assign start_evt = cd.btn_start & ~start_prev_q;

    tick_prescaler #(
        .SCALE_FACTOR(SCALE_FACTOR)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (presc_clear),
        .enable  (presc_en),
        .tick    (tick)
    );

    // Next state, count and pulse; priority is clear > start edge > tick
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        done_pulse_d = 1'b0;
        presc_clear  = 1'b0;
        presc_en     = 1'b0;
        if (cd.btn_clear) begin
            state_d     = IDLE;
            count_d     = cd.load_value;
            presc_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // IDLE previews the switches; DONE pins the count at 0
                    count_d = (state_q == IDLE) ? cd.load_value : '0;
                    if (start_evt) begin
                        presc_clear = 1'b1;
                        if (cd.load_value == '0) begin
                            state_d      = DONE;
                            count_d      = '0;
                            done_pulse_d = 1'b1;
                        end else begin
                            state_d = RUN;
                            count_d = cd.load_value;
                        end
                    end
                end
                RUN: begin
                    if (start_evt) begin
                        // Prescaler is not enabled here, so a tick due now is dropped
                        state_d = PAUSE;
                    end else begin
                        presc_en = 1'b1;
                        if (tick && count_q != '0) begin
                            count_d = count_q - 1'b1;
                            if (count_q == COUNT_W'(1)) begin
                                state_d      = DONE;
                                done_pulse_d = 1'b1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (start_evt) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers; start_prev resets high so a held button cannot start
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            done_pulse_q <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            done_pulse_q <= done_pulse_d;
            start_prev_q <= cd.btn_start;
        end
    end

    assign cd.count      = count_q;
    assign cd.running    = (state_q == RUN);
    assign cd.paused     = (state_q == PAUSE);
    assign cd.expired    = (state_q == DONE);
    assign cd.done_pulse = done_pulse_q;
    assign cd.state_dbg  = state_q;

endmodule

// File: tb/tb_countdown_controller.sv
// Bench for countdown_controller: directed scenarios plus random button
// traffic, all compared against a cycle-level behavioural model.
module tb_countdown_controller;
    import countdown_pkg::*;

    localparam int SF  = 4;
    localparam int SFB = 100;
    localparam int CW  = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic rst100_n;
    always #5 clk = ~clk;

    countdown_controller_if #(.COUNT_W(CW)) a ();
    countdown_controller_if #(.COUNT_W(CW)) b ();

    countdown_controller #(.SCALE_FACTOR(SF), .COUNT_W(CW)) u_dut (
        .clk     (clk),
        .reset_n (rst_n),
        .cd      (a)
    );

    countdown_controller #(.SCALE_FACTOR(SFB), .COUNT_W(CW)) u_dut100 (
        .clk     (clk),
        .reset_n (rst100_n),
        .cd      (b)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [CW+3:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timer modes: waiting for start, counting, frozen, finished.
    typedef enum {M_IDLE, M_COUNT, M_FROZEN, M_FINISHED} mode_t;
    mode_t m_mode   = M_IDLE;
    int    m_cnt    = 0;
    int    m_elap   = 0;   // cycles elapsed toward the next decrement
    bit    m_pulse  = 0;
    bit    m_prev   = 1;

    task automatic model_step(input bit bs, input bit bc, input int lv, input bit rn);
        bit evt;
        if (!rn) begin
            m_mode = M_IDLE; m_cnt = 0; m_elap = 0; m_pulse = 0; m_prev = 1;
            return;
        end
        evt     = bs && !m_prev;
        m_prev  = bs;
        m_pulse = 0;
        if (bc) begin
            m_mode = M_IDLE; m_elap = 0; m_cnt = lv;
        end else if (m_mode == M_IDLE || m_mode == M_FINISHED) begin
            m_cnt = (m_mode == M_IDLE) ? lv : 0;
            if (evt) begin
                m_elap = 0;
                if (lv == 0) begin
                    m_mode = M_FINISHED; m_cnt = 0; m_pulse = 1;
                end else begin
                    m_mode = M_COUNT; m_cnt = lv;
                end
            end
        end else if (m_mode == M_COUNT) begin
            if (evt) m_mode = M_FROZEN;
            else begin
                m_elap++;
                if (m_elap == SF) begin
                    m_elap = 0;
                    m_cnt  = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_mode = M_FINISHED; m_pulse = 1;
                    end
                end
            end
        end else begin
            if (evt) m_mode = M_COUNT;
        end
    endtask

    // ---------------- driver ----------------
    // Apply one cycle of inputs to the SF=4 instance and check all outputs.
    task automatic drive(input bit bs, input bit bc, input int lv, input bit rn);
        logic [CW+3:0] e;
        a.btn_start  = bs;
        a.btn_clear  = bc;
        a.load_value = CW'(lv);
        rst_n        = rn;
        @(posedge clk);
        model_step(bs, bc, lv, rn);
        exp_q.push_back({CW'(m_cnt), m_mode == M_COUNT, m_mode == M_FROZEN,
                         m_mode == M_FINISHED, m_pulse});
        #1;
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("count",      32'(a.count),      32'(e[CW+3:4]));
            chk("running",    32'(a.running),    32'(e[3]));
            chk("paused",     32'(a.paused),     32'(e[2]));
            chk("expired",    32'(a.expired),    32'(e[1]));
            chk("done_pulse", 32'(a.done_pulse), 32'(e[0]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        int cyc;
        int decs;
        int prev_cnt;
        bit bs;
        int lv;

        a.btn_start = 0; a.btn_clear = 0; a.load_value = '0; rst_n = 0;
        b.btn_start = 0; b.btn_clear = 0; b.load_value = '0; rst100_n = 0;

        // Reset state
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("rst_count", 32'(a.count), 0);
        chk("rst_flags", 32'({a.running, a.paused, a.expired, a.done_pulse}), 0);

        // Basic countdown from 3: decrements at cycles 5, 9, 13
        drive(0, 0, 3, 1);
        drive(1, 0, 3, 1);
        cyc = 1;
        chk("t1_count_c1", 32'(a.count), 3);
        chk("t1_run_c1", 32'(a.running), 1);
        for (int i = 0; i < 13; i++) begin
            drive(1, 0, 3, 1);
            cyc++;
            if (cyc == 5)  chk("t1_count_c5", 32'(a.count), 2);
            if (cyc == 9)  chk("t1_count_c9", 32'(a.count), 1);
            if (cyc == 13) begin
                chk("t1_count_c13", 32'(a.count), 0);
                chk("t1_pulse_c13", 32'(a.done_pulse), 1);
                chk("t1_exp_c13", 32'(a.expired), 1);
            end
            if (cyc == 14) chk("t1_pulse_c14", 32'(a.done_pulse), 0);
        end

        // Pause after 6 RUN cycles, idle 20, resume keeps prescaler phase
        drive(0, 0, 0, 0);
        drive(0, 0, 3, 1);
        drive(1, 0, 3, 1);
        for (int i = 0; i < 6; i++) drive(0, 0, 3, 1);
        drive(1, 0, 3, 1);
        chk("t2_paused", 32'(a.paused), 1);
        chk("t2_frozen", 32'(a.count), 2);
        for (int i = 0; i < 20; i++) drive(0, 0, 7, 1);
        chk("t2_still_frozen", 32'(a.count), 2);
        drive(1, 0, 7, 1);
        chk("t2_resumed", 32'(a.running), 1);
        drive(0, 0, 7, 1);
        chk("t2_resume_c1", 32'(a.count), 2);
        drive(0, 0, 7, 1);
        chk("t2_resume_c2", 32'(a.count), 1);
        for (int i = 0; i < 6; i++) drive(0, 0, 7, 1);
        chk("t2_done", 32'(a.expired), 1);

        // Button held through reset must not start
        drive(1, 0, 5, 0);
        drive(1, 0, 5, 0);
        for (int i = 0; i < 5; i++) drive(1, 0, 5, 1);
        chk("t3_no_start", 32'(a.running), 0);
        chk("t3_preview", 32'(a.count), 5);
        drive(0, 0, 5, 1);
        drive(1, 0, 5, 1);
        chk("t3_started", 32'(a.running), 1);

        // Zero load: straight to DONE with a single pulse, twice
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 1);
        chk("t4_exp", 32'(a.expired), 1);
        chk("t4_pulse", 32'(a.done_pulse), 1);
        drive(1, 0, 0, 1);
        chk("t4_pulse_once", 32'(a.done_pulse), 0);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 1);
        chk("t4_pulse_again", 32'(a.done_pulse), 1);
        drive(0, 0, 0, 1);

        // Clear with a start edge at count 7, then reset mid-run
        drive(0, 0, 0, 0);
        drive(0, 0, 9, 1);
        drive(1, 0, 9, 1);
        guard = 0;
        while (m_cnt != 7 && guard < 100) begin
            drive(0, 0, 9, 1);
            guard++;
        end
        chk("t5_reach7", 32'(guard < 100), 1);
        drive(1, 1, 9, 1);
        chk("t5_clr_run", 32'(a.running), 0);
        chk("t5_clr_pulse", 32'(a.done_pulse), 0);
        drive(0, 0, 12, 1);
        chk("t5_track", 32'(a.count), 12);
        drive(1, 0, 12, 1);
        for (int i = 0; i < 6; i++) drive(0, 0, 12, 1);
        drive(0, 0, 12, 0);
        chk("t5_rst_all", 32'({a.count, a.running, a.paused, a.expired, a.done_pulse}), 0);

        // Random button traffic
        bs = 0;
        lv = 3;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) bs = ~bs;
            if ($urandom_range(0, 9) == 0) lv = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 5);
            drive(bs, $urandom_range(0, 49) == 0, lv, $urandom_range(0, 149) != 0);
        end

        // SCALE_FACTOR=100, load 10: expiry exactly 1000 cycles after the start edge
        @(posedge clk); #1;
        rst100_n = 1;
        b.load_value = 11'd10;
        @(posedge clk); #1;
        b.btn_start = 1;
        @(posedge clk); #1;
        chk("t6_start", 32'(b.running), 1);
        cyc = 0;
        decs = 0;
        prev_cnt = 10;
        while (!b.expired && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (32'(b.count) != prev_cnt) decs++;
            prev_cnt = 32'(b.count);
        end
        chk("t6_cycles", 32'(cyc), 1000);
        chk("t6_decs", 32'(decs), 10);
        chk("t6_pulse", 32'(b.done_pulse), 1);

        // Resync the main instance after it sat unchecked
        drive(0, 0, 0, 0);
        chk("final_q_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_controller.md
Name: countdown_controller

Overview:
- Sequencing FSM for the board's countdown timer datapath.
- Loads a start value from the switches, runs a SCALE_FACTOR prescaler, decrements the count once per tick, and supports pause/resume and clear.
- Flags expiry so top_level can drive the HEX and LEDR displays.
- Sits between the debounced KEY/SW inputs and the display decoders in top_level.

Parameters:
- SCALE_FACTOR, 50000, clk cycles per count tick (50000 = 1 ms at 50 MHz; benches use a small value such as 4 or 100).
- COUNT_W, 11, width of the load value and the count.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset_n  in  1  synchronous, active-low reset
- btn_start  in  1  start/pause button level, active-high, already synchronised and debounced
- btn_clear  in  1  clear level, active-high, already synchronised
- load_value  in  COUNT_W  countdown start value from SW
- count  out  COUNT_W  current count value
- running  out  1  high in RUN
- paused  out  1  high in PAUSE
- expired  out  1  high in DONE
- done_pulse  out  1  one-cycle pulse when the count reaches 0

Behaviour:
- One clock, synchronous active-low reset; all state updates on the rising edge of clk.
- Reset (reset_n=0 at an edge), from any state, including mid-count:
  - state=IDLE, count=0, prescaler=0, done_pulse=0.
  - running, paused and expired all 0.
  - start_prev=1, so a button held through reset cannot generate a start.
- Start edge: start_evt = btn_start & ~start_prev. start_prev <= btn_start every cycle.
- States: IDLE, RUN, PAUSE, DONE. The running/paused/expired outputs decode the state directly (Moore).
- Priority every cycle: reset_n > btn_clear > start_evt > tick.
- btn_clear=1 in any state: next state IDLE, prescaler=0, done_pulse=0.
- IDLE:
  - count <= load_value every cycle (live preview).
  - start_evt with load_value!=0: next state RUN, count=load_value, prescaler=0.
  - start_evt with load_value==0: next state DONE, count=0, done_pulse=1 on the next cycle.
- RUN:
  - prescaler increments each cycle. When it equals SCALE_FACTOR-1 it wraps to 0 and asserts the internal tick.
  - On tick, count <= count-1.
  - Tick with count==1: count=0, next state DONE, done_pulse=1 in the same cycle that count becomes 0.
  - start_evt: next state PAUSE. prescaler and count hold; any tick in that cycle is discarded.
- PAUSE:
  - prescaler and count hold.
  - start_evt: next state RUN; the prescaler resumes from its held value.
- DONE:
  - count=0, expired=1.
  - start_evt: reload, with the same rules as a start from IDLE (RUN with count=load_value, or back to DONE with a fresh done_pulse if load_value==0).
- Latency:
  - start_evt sampled at edge N: state and count are valid after edge N.
  - First decrement after exactly SCALE_FACTOR cycles in RUN.
  - A load of V expires V*SCALE_FACTOR cycles after the start.
- Arithmetic:
  - count is unsigned COUNT_W and never decrements below 0; there is no wrap to all-ones.
  - Prescaler width is $clog2(SCALE_FACTOR), minimum 1.
  - SCALE_FACTOR=1 means a tick every cycle.
- load_value changes during RUN, PAUSE or DONE are ignored until the next (re)start.
- done_pulse is high for exactly one cycle per expiry; it is never high in IDLE or PAUSE.

Decomposition:
- Package countdown_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t.
  - Default SCALE_FACTOR and COUNT_W constants, shared with top_level and the bench.
- One natural sub-module, tick_prescaler: parameter SCALE_FACTOR; inputs clk, reset_n, clear, enable; output tick.
  - Counts only while enable=1.
  - clear zeroes the count.
  - tick is high on the wrap cycle.
- The FSM and count register stay in countdown_controller.

Test Plan (SCALE_FACTOR=4 unless stated):
- Reset, load_value=3, start edge at cycle 0 -> count=3 and running=1 at cycle 1; count=2 at cycle 5, 1 at cycle 9, 0 at cycle 13 with done_pulse=1 for one cycle and expired=1 from cycle 13 on.
- Start, then a second start edge after 6 cycles in RUN -> paused=1 and count frozen at 2; after 20 idle cycles a third edge resumes, and the remaining decrements occur with the original prescaler phase (next decrement 2 cycles after resume).
- Reset released with btn_start held high, then load_value=5 -> no start while the button stays high; the first start occurs only after a low-then-high edge.
- load_value=0 with a start edge -> DONE on the next cycle, done_pulse=1 once, count stays 0; another start edge -> another single done_pulse.
- btn_clear asserted together with a start edge while in RUN at count=7 -> IDLE, count tracks load_value, running=0, no done_pulse; reset_n=0 mid-RUN -> all outputs 0 on the next cycle.
- SCALE_FACTOR=100, load_value=10 (top_level bench configuration) -> expired=1 exactly 1000 cycles after the start edge, with exactly 10 decrements observed.
